// File: rtl/rijndael_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key schedule.
package rijndael_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_SUB  = 2'd2
  } state_e;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int unsigned NUM_ROUND_KEYS = 11;
  localparam int unsigned RK_IDX_W       = 4;
  localparam int unsigned LAST_RK_IDX    = NUM_ROUND_KEYS - 1;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/rijndael_sbox.sv
// Combinational AES forward S-box lookup.
module rijndael_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_idx;

  always_comb begin
    bit_idx = {~a_i, 3'b000};
    s_o     = SBOX_TABLE[bit_idx +: 8];
  end

endmodule

// File: rtl/rijndael_key_schedule.sv
// AES-128 round-key generator streaming rk0..rk10 over a valid/ready port.
// RIJNDAEL_KS_SERIAL_SBOX_EN selects one shared S-box (4-cycle SUB) instead of four.
module rijndael_key_schedule
  import rijndael_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         busy
);

  state_e                state_q;
  block_t                rk_q;
  logic [RK_IDX_W-1:0]   rk_idx_q;
  logic [7:0]            rcon_q;
  logic                  key_ready_q;
  logic                  rk_valid_q;
  logic                  busy_q;

  word_t  w0, w1, w2, w3, rot_w;
  word_t  temp_c;
  logic   sub_done_c;
  block_t next_rk_c;

  assign w0    = rk_q[127:96];
  assign w1    = rk_q[95:64];
  assign w2    = rk_q[63:32];
  assign w3    = rk_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

`ifdef RIJNDAEL_KS_SERIAL_SBOX_EN
  logic [1:0]  byte_cnt_q;
  logic [23:0] temp_hi_q;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;

  // Byte 0 of RotWord(w3) is substituted first.
  always_comb begin
    sbox_in = rot_w[31:24];
    unique case (byte_cnt_q)
      2'd0: sbox_in = rot_w[31:24];
      2'd1: sbox_in = rot_w[23:16];
      2'd2: sbox_in = rot_w[15:8];
      2'd3: sbox_in = rot_w[7:0];
      default: sbox_in = rot_w[31:24];
    endcase
  end

  rijndael_sbox u_sbox (
    .a_i (sbox_in),
    .s_o (sbox_out)
  );

  // The last byte is used straight from the S-box so the round completes on count 3.
  assign temp_c     = {temp_hi_q, sbox_out} ^ {rcon_q, 24'h000000};
  assign sub_done_c = (byte_cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      temp_hi_q  <= 24'h000000;
    end else if (state_q == ST_SUB) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      unique case (byte_cnt_q)
        2'd0: temp_hi_q[23:16] <= sbox_out;
        2'd1: temp_hi_q[15:8]  <= sbox_out;
        2'd2: temp_hi_q[7:0]   <= sbox_out;
        default: ;
      endcase
    end else begin
      byte_cnt_q <= 2'd0;
    end
  end
`else
  word_t sub_w;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    rijndael_sbox u_sbox (
      .a_i (rot_w[8*g +: 8]),
      .s_o (sub_w[8*g +: 8])
    );
  end

  assign temp_c     = sub_w ^ {rcon_q, 24'h000000};
  assign sub_done_c = 1'b1;
`endif

  // Next round key: each word chains off the freshly computed previous word.
  always_comb begin
    next_rk_c[127:96] = w0 ^ temp_c;
    next_rk_c[95:64]  = w1 ^ next_rk_c[127:96];
    next_rk_c[63:32]  = w2 ^ next_rk_c[95:64];
    next_rk_c[31:0]   = w3 ^ next_rk_c[63:32];
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rk_q        <= '0;
      rk_idx_q    <= '0;
      rcon_q      <= 8'h01;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_valid && key_ready_q) begin
            state_q     <= ST_OUT;
            rk_q        <= key;
            rk_idx_q    <= '0;
            rcon_q      <= 8'h01;
            key_ready_q <= 1'b0;
            rk_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_OUT: begin
          if (rk_ready) begin
            rk_valid_q <= 1'b0;
            if (rk_idx_q == RK_IDX_W'(LAST_RK_IDX)) begin
              state_q     <= ST_IDLE;
              key_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q <= ST_SUB;
            end
          end
        end
        ST_SUB: begin
          if (sub_done_c) begin
            state_q    <= ST_OUT;
            rk_q       <= next_rk_c;
            rk_idx_q   <= rk_idx_q + RK_IDX_W'(1);
            rcon_q     <= xtime(rcon_q);
            rk_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          key_ready_q <= 1'b1;
          rk_valid_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk        = rk_q;
  assign rk_idx    = rk_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rijndael_key_schedule.sv
// Self-checking bench for rijndael_key_schedule against a GF(2^8)-arithmetic key expansion model.
module tb_rijndael_key_schedule;
  import rijndael_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         busy;

`ifdef RIJNDAEL_KS_SERIAL_SBOX_EN
  localparam int GAP = 5;
`else
  localparam int GAP = 2;
`endif

  rijndael_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_idx    (rk_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  block_t exp_rk [0:10];
  block_t obs_rk [0:10];

  typedef struct {
    block_t key;
    int     idx;
    block_t exp;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: S-box from field inverse + affine map, then FIPS-197 word recurrence.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand(input block_t k);
    word_t      w [0:43];
    word_t      t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Caller must be at a negedge. Runs one full schedule with optional stall/abort/held second key.
  task automatic do_key(input block_t k, input int stall_idx, input int abort_idx,
                        input bit hold, input block_t k2);
    int     n;
    block_t held_rk;
    expand(k);
    key       = k;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("key_ready_wait", 128'(key_ready), 128'(1));
    if (!key_ready) begin
      key_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold) key = k2;
    else      key_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rk_valid && n < 20);
      chk("rk_valid", 128'(rk_valid), 128'(1));
      chk($sformatf("rk%0d", i), rk, exp_rk[i]);
      chk("rk_idx", 128'(rk_idx), 128'(i));
      chk("gap", 128'(n), 128'((i == 0) ? 1 : GAP));
      chk("key_ready_busy", 128'({key_ready, busy}), 128'(2'b01));
      obs_rk[i] = rk;
      if (i == abort_idx) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 128'({key_ready, rk_valid, busy, rk_idx}), 128'(7'b1000000));
        chk("abort_rk", rk, 128'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        key_valid = 1'b0;
        return;
      end
      if (i == stall_idx) begin
        rk_ready = 1'b0;
        held_rk  = rk;
        for (int c = 0; c < 7; c++) begin
          @(negedge clk);
          chk("stall_rk", rk, held_rk);
          chk("stall_idx_valid", 128'({rk_idx, rk_valid}), 128'({4'(i), 1'b1}));
        end
        rk_ready = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("idle_outs", 128'({key_ready, rk_valid, busy}), 128'(3'b100));
    chk("idle_rk_kept", rk, exp_rk[10]);
  endtask

  localparam block_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  vec_t vecs [5];

  initial begin
    block_t k2;
    vecs[0] = '{FIPS_KEY, 0,  FIPS_KEY};
    vecs[1] = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{128'h0,   1,  128'h62636363626363636263636362636363};
    vecs[4] = '{128'h0,   2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};

    #12;
    chk("reset_outs", 128'({key_ready, rk_valid, busy, rk_idx}), 128'(7'b1000000));
    chk("reset_rk", rk, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vectors, each key run once then its table rows compared.
    for (int v = 0; v < 5; v++) begin
      if (v == 0 || vecs[v].key != vecs[v-1].key) do_key(vecs[v].key, -1, -1, 1'b0, '0);
      chk($sformatf("kat_v%0d", v), obs_rk[vecs[v].idx], vecs[v].exp);
    end

    // Backpressure at round 3.
    do_key(FIPS_KEY, 3, -1, 1'b0, '0);
    chk("stall_rk10", obs_rk[10], vecs[2].exp);

    // Second key held on key_valid throughout; accepted right after round 10.
    k2 = {$urandom, $urandom, $urandom, $urandom};
    do_key(FIPS_KEY, -1, -1, 1'b1, k2);
    chk("hold_rk10", obs_rk[10], vecs[2].exp);
    do_key(k2, -1, -1, 1'b0, '0);

    // Reset mid-schedule, then a clean restart.
    do_key(FIPS_KEY, -1, 5, 1'b0, '0);
    @(negedge clk);
    do_key(FIPS_KEY, -1, -1, 1'b0, '0);
    chk("restart_rk1", obs_rk[1], vecs[1].exp);

    // Random keys with a random stall point.
    for (int r = 0; r < 4; r++) begin
      do_key({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 10)), -1, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
